// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked multi-cycle adder: FSM states and
// slice-geometry helpers used at elaboration time.
package chunked_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_slices(input int data_w, input int chunk_w);
      return data_w / chunk_w;
   endfunction

   // A single slice still needs a 1-bit index so the sequencer logic stays uniform.
   function automatic int calc_idx_w(input int n_slices);
      return (n_slices <= 1) ? 1 : $clog2(n_slices);
   endfunction

   function automatic bit cfg_ok(input int data_w, input int chunk_w);
      return (chunk_w > 0) && (data_w >= chunk_w) && ((data_w % chunk_w) == 0);
   endfunction

endpackage

// File: rtl/chunked_adder_ripple.sv
// Purely combinational CHUNK_WIDTH-bit ripple-carry adder built from
// full-adder cells; this is the only arithmetic on the per-cycle path.
module chunk_ripple_adder #(
   parameter int CHUNK_WIDTH = 4
) (
   input  logic [CHUNK_WIDTH-1:0] a,
   input  logic [CHUNK_WIDTH-1:0] b,
   input  logic                   ci,
   output logic [CHUNK_WIDTH-1:0] s,
   output logic                   co
);

   logic [CHUNK_WIDTH:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
   end

   assign co = w_c[CHUNK_WIDTH];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle wide adder: buffers operands, then adds one CHUNK_WIDTH slice
// per clock, carrying between slices through a register.
module chunked_adder
   import chunked_adder_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int CHUNK_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  ci,
   input  logic                  in_vld,
   output logic                  in_rd,
   output logic [DATA_WIDTH-1:0] s,
   output logic                  co,
   output logic                  out_vld,
   input  logic                  out_rd
);

   localparam int N     = calc_slices(DATA_WIDTH, CHUNK_WIDTH);
   localparam int IDX_W = calc_idx_w(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if (!cfg_ok(DATA_WIDTH, CHUNK_WIDTH)) begin : g_cfg_err
      $error("chunked_adder: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
   end

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_accept;
   logic                    w_step;

   logic [IDX_W-1:0]        r_idx;
   logic [DATA_WIDTH-1:0]   r_a;
   logic [DATA_WIDTH-1:0]   r_b;
   logic [DATA_WIDTH-1:0]   r_s;
   logic                    r_carry;

   logic [CHUNK_WIDTH-1:0]  w_a_slice;
   logic [CHUNK_WIDTH-1:0]  w_b_slice;
   logic [CHUNK_WIDTH-1:0]  w_sum_slice;
   logic                    w_slice_co;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_vld) begin
               w_accept    = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            w_step = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_rd) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_a_slice = r_a[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign w_b_slice = r_b[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];

   chunk_ripple_adder #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_slice_add (
      .a  (w_a_slice),
      .b  (w_b_slice),
      .ci (r_carry),
      .s  (w_sum_slice),
      .co (w_slice_co)
   );

   // Data registers are reset too so that an aborted operation never leaks
   // a partial sum onto s/co.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_idx   <= '0;
         r_a     <= a;
         r_b     <= b;
         r_carry <= ci;
      end else if (w_step) begin
         r_s[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_sum_slice;
         r_carry                               <= w_slice_co;
         if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   assign in_rd   = (r_state == IDLE);
   assign out_vld = (r_state == DONE);
   assign s       = r_s;
   assign co      = r_carry;

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Multi-cycle wide adder that splits DATA_WIDTH-bit operands into CHUNK_WIDTH-bit slices and adds one slice per clock through a small ripple-carry adder, chaining the carry between cycles in a register. It sits between a vld/rd operand producer and a vld/rd result consumer. It wraps the narrow ripple-adder datapath with operand buffering, a slice sequencer and handshakes, so wide additions run on a short combinational path.

## Interface
- DATA_WIDTH, 16: operand/result width; must be an integer multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 4: slice width added per cycle (the ripple-adder width).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  DATA_WIDTH  operand A.
- b  in  DATA_WIDTH  operand B.
- ci  in  1  carry-in of the whole addition.
- in_vld  in  1  operands valid.
- in_rd  out  1  block ready to accept operands.
- s  out  DATA_WIDTH  sum, registered.
- co  out  1  carry-out of the most significant slice, registered.
- out_vld  out  1  s/co valid.
- out_rd  in  1  consumer ready.

## Operation
- N = DATA_WIDTH / CHUNK_WIDTH, with N ≥ 1. The slice index idx is clog2(N) bits wide, minimum 1.
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_rd=1 and out_vld=0.
  - On in_vld=1, capture a, b and ci into a_q, b_q and carry_q. Set idx=0 and go to BUSY.
- BUSY:
  - in_rd=0 and out_vld=0.
  - Each cycle the slice adder computes a_q[idx*CW +: CW] + b_q[idx*CW +: CW] + carry_q.
  - The sum slice is written to s_q[idx*CW +: CW] and the slice carry-out to carry_q.
  - When idx==N-1, go to DONE. Otherwise idx increments.
- DONE:
  - out_vld=1, co=carry_q and s=s_q. in_rd=0.
  - On out_rd=1, go to IDLE.
  - s and co hold stable while out_rd=0.
- Arithmetic: the result is exactly {co, s} = a + b + ci, modulo 2^(DATA_WIDTH+1). No overflow flag.
- The block ignores in_vld while not in IDLE. Operands do not need to stay stable after acceptance.
- Asynchronous reset in any state, including mid-BUSY:
  - state=IDLE, idx=0, carry_q=0, s_q=0, a_q=b_q=0.
  - Outputs: out_vld=0, s=0, co=0, in_rd=1.
  - The in-flight operation is discarded and no partial result is ever presented.

## Timing
- Acceptance happens at the rising edge where in_vld & in_rd, edge T.
- BUSY occupies cycles T..T+N-1 and processes one slice per edge.
- out_vld first becomes 1 in the cycle after edge T+N, so latency is N cycles.
- Back-to-back throughput: with out_rd held at 1 and in_vld held at 1, one result every N+2 cycles (IDLE, N×BUSY, DONE).
- in_rd and out_vld are decoded directly from state registers, with no combinational path from in_vld or out_rd.
- The critical path is one CHUNK_WIDTH ripple plus the slice mux.
- N=1: a single BUSY cycle; the behaviour is otherwise identical.

## Structure
- A shared package holds:
  - the state enum {IDLE, BUSY, DONE};
  - the helper function computing N and the idx width;
  - the elaboration check that DATA_WIDTH % CHUNK_WIDTH == 0.
- One sub-module, chunk_ripple_adder, parameterised by CHUNK_WIDTH:
  - purely combinational, built from full-adder cells;
  - ports a, b, ci, s, co.
- The top level holds the FSM, operand/result registers, carry register and slice muxing.

## Test plan
- Carry across slices: DATA_WIDTH=16, CHUNK_WIDTH=4; a=0x00FF, b=0x0001, ci=0 → s=0x0100, co=0. out_vld rises exactly 4 cycles after acceptance.
- Full carry chain: a=0xFFFF, b=0x0000, ci=1 → s=0x0000, co=1. Also a=0x8000, b=0x8000, ci=0 → s=0x0000, co=1.
- Back-pressure and ignored input: hold out_rd=0 for 5 cycles in DONE → s and co stay stable and out_vld stays at 1. Pulse in_vld with new operands during BUSY and DONE → in_rd stays 0 and the result is unchanged.
- Reset mid-operation: assert rst at the 2nd BUSY cycle of 0x1234+0x4321 → out_vld=0, s=0, co=0 and in_rd=1 immediately. The next accepted 0x0001+0x0002 → s=0x0003, co=0.
- Streaming: 100 random (a, b, ci) tuples with random in_vld/out_rd gaps → every result equals the reference sum, in order, with none dropped or duplicated.
- Degenerate configuration: DATA_WIDTH=4, CHUNK_WIDTH=4; a=0xF, b=0x1, ci=0 → s=0x0, co=1, out_vld after 1 cycle.
